// File: rtl/mgmt_mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO master.
package mgmt_mdio_pkg;

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, TA, DATA, DONE} state_e;

  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  // Number of MDC bits spent in each serialising state.
  function automatic logic [5:0] seg_bits(state_e s, int pre_len);
    logic [5:0] n;
    case (s)
      PREAMBLE: n = 6'(pre_len);
      HEADER:   n = 6'd14;
      TA:       n = 6'd2;
      DATA:     n = 6'd16;
      default:  n = 6'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mgmt_mdio_clkgen.sv
// MDC generator: CLK_DIV clks low then CLK_DIV clks high per bit.
// bit_start is high on the clk whose closing edge opens a bit's low phase,
// so registered bus outputs change on the first low clk; sample marks the
// last high clk of each bit.
module mgmt_mdio_clkgen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic bit_start,
  output logic sample
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       run;

  // Half-period counter; mdc toggles each time it wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      mdc <= 1'b0;
      run <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
      run <= 1'b0;
    end else if (!run) begin
      run <= 1'b1;
      cnt <= '0;
      mdc <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign sample    = en && run && mdc && (cnt == LAST);
  assign bit_start = en && (!run || (mdc && (cnt == LAST)));

endmodule

// File: rtl/mgmt_mdio_master.sv
// Clause-22 MDIO master: one register access per accepted command,
// one response per completed frame.
module mgmt_mdio_master
  import mgmt_mdio_pkg::*;
#(
  parameter int CLK_DIV      = 50,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [PHYAD_W-1:0] cmd_phy_addr,
  input  logic [REGAD_W-1:0] cmd_reg_addr,
  input  logic [DATA_W-1:0]  cmd_wdata,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               busy,
  output logic               mdc,
  output logic               mdio_out,
  output logic               mdio_oe,
  input  logic               mdio_in
);

  state_e        state, state_n;
  logic [5:0]    bcnt, bcnt_n;
  logic [31:0]   sreg, sreg_n;   // ST, OP, PHYAD, REGAD, TA, DATA; MSB is next bit
  logic [14:0]   rd_sh;
  logic [1:0]    sync;
  logic          wr;
  logic          en, bit_start, sample;

  assign cmd_ready = (state == IDLE);
  assign busy      = !cmd_ready;
  assign rsp_valid = (state == DONE);
  assign en        = state inside {PREAMBLE, HEADER, TA, DATA};

  mgmt_mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mdc       (mdc),
    .bit_start (bit_start),
    .sample    (sample)
  );

  // State and per-state bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
    end
  end

  // Next state: segments advance on the last high clk of their final bit.
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    sreg_n  = sreg;
    case (state)
      IDLE: if (cmd_valid) begin
        if (PREAMBLE_LEN == 0) state_n = HEADER;
        else                   state_n = PREAMBLE;
        bcnt_n = '0;
        sreg_n = {MDIO_ST, (cmd_write ? MDIO_OP_WRITE : MDIO_OP_READ),
                  cmd_phy_addr, cmd_reg_addr,
                  (cmd_write ? 2'b10 : 2'b11),
                  (cmd_write ? cmd_wdata : 16'hFFFF)};
      end
      DONE: state_n = IDLE;
      default: if (sample) begin
        if (state != PREAMBLE) sreg_n = {sreg[30:0], 1'b0};
        if (bcnt == seg_bits(state, PREAMBLE_LEN) - 6'd1) begin
          bcnt_n = '0;
          case (state)
            PREAMBLE: state_n = HEADER;
            HEADER:   state_n = TA;
            TA:       state_n = DATA;
            default:  state_n = DONE;
          endcase
        end else begin
          bcnt_n = bcnt + 6'd1;
        end
      end
    endcase
  end

  // Frame shifter, synchroniser, read assembly and registered bus drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      wr        <= 1'b0;
      sync      <= 2'b11;
      rd_sh     <= '0;
      rsp_rdata <= '0;
      mdio_out  <= 1'b1;
      mdio_oe   <= 1'b0;
    end else begin
      sreg <= sreg_n;
      sync <= {sync[0], mdio_in};
      if (cmd_valid && cmd_ready) wr <= cmd_write;
      if (sample && state == DATA) rd_sh <= {rd_sh[13:0], sync[1]};
      if (sample && state == DATA && state_n == DONE && !wr)
        rsp_rdata <= {rd_sh, sync[1]};
      if (state_n == DONE || state_n == IDLE) begin
        mdio_out <= 1'b1;
        mdio_oe  <= 1'b0;
      end else if (bit_start) begin
        mdio_out <= (state_n == PREAMBLE) ? 1'b1 : sreg_n[31];
        mdio_oe  <= wr || (state_n inside {PREAMBLE, HEADER});
      end
    end
  end

endmodule

// File: tb/tb_mgmt_mdio_master.sv
// Bench for mgmt_mdio_master: two instances (32-bit and empty preamble)
// sharing stimulus through a select, a PHY model and a frame-level model.
module tb_mgmt_mdio_master;

  localparam int D      = 4;
  localparam int PRE_A  = 32;
  localparam int PRE_B  = 0;
  localparam int BUDGET = 3000;

  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, mdio_in = 1'b1;
  logic [4:0]  cmd_phy_addr = '0, cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;

  logic a_ready, a_busy, a_rsp, a_mdc, a_out, a_oe;
  logic b_ready, b_busy, b_rsp, b_mdc, b_out, b_oe;
  logic [15:0] a_rdata, b_rdata;

  wire a_valid = cmd_valid & ~sel;
  wire b_valid = cmd_valid & sel;
  wire m_ready = sel ? b_ready : a_ready;
  wire m_busy  = sel ? b_busy  : a_busy;
  wire m_rsp   = sel ? b_rsp   : a_rsp;
  wire m_mdc   = sel ? b_mdc   : a_mdc;
  wire m_out   = sel ? b_out   : a_out;
  wire m_oe    = sel ? b_oe    : a_oe;
  wire [15:0] m_rdata = sel ? b_rdata : a_rdata;

  always #5 clk = ~clk;

  mgmt_mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(PRE_A)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(a_rsp), .rsp_rdata(a_rdata), .busy(a_busy),
    .mdc(a_mdc), .mdio_out(a_out), .mdio_oe(a_oe), .mdio_in(mdio_in));

  mgmt_mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(PRE_B)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(b_rsp), .rsp_rdata(b_rdata), .busy(b_busy),
    .mdc(b_mdc), .mdio_out(b_out), .mdio_oe(b_oe), .mdio_in(mdio_in));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  logic mdc_q = 1'b0;
  bit bq[$], oq[$];
  int rsp_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] last_rd [2];
  logic [15:0] phy_word = '0;
  bit phy_present = 1'b0;
  int phy_pre = PRE_A;

  // Edge counter: after active edge E, cyc == E.
  always @(posedge clk) cyc <= cyc + 1;

  // Record bus bits at each MDC rise and every response pulse.
  always @(negedge clk) begin
    if (m_mdc && !mdc_q) begin
      bq.push_back(m_out);
      oq.push_back(m_oe);
    end
    mdc_q <= m_mdc;
    if (m_rsp) begin
      rsp_q.push_back(cyc);
      rd_q.push_back(m_rdata);
    end
  end

  // PHY: drives data bits from each low phase; pull-up otherwise.
  always @(negedge m_mdc) begin
    if (phy_present && bq.size() >= phy_pre + 16 && bq.size() < phy_pre + 32)
      mdio_in <= phy_word[15 - (bq.size() - phy_pre - 16)];
    else
      mdio_in <= 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_accept(output int t);
    t = -1;
    for (int i = 0; i < BUDGET; i++) begin
      if (m_ready) begin t = cyc + 1; break; end
      @(negedge clk);
    end
    if (t >= 0) @(posedge clk);
    chk("accept_seen", 64'(t >= 0), 64'(1));
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < BUDGET && rsp_q.size() < n; i++) @(posedge clk);
    chk("rsp_seen", 64'(rsp_q.size() >= n), 64'(1));
  endtask

  // Expected frame from the field layout; data bits compared only where driven.
  task automatic check_frame(input int pre, input bit wr, input logic [4:0] phy,
                             input logic [4:0] rg, input logic [15:0] wdata,
                             input int b0, input string tag);
    logic [31:0] f;
    logic [63:0] eo, ee, ao, ae;
    bit b, oe;
    f  = {2'b01, (wr ? 2'b01 : 2'b10), phy, rg, (wr ? 2'b10 : 2'b00), (wr ? wdata : 16'h0000)};
    eo = '0; ee = '0; ao = '0; ae = '0;
    for (int i = 0; i < pre + 32; i++) begin
      b  = (i < pre) ? 1'b1 : f[31 - (i - pre)];
      oe = wr || (i < pre + 14);
      ee = {ee[62:0], b & oe};
      eo = {eo[62:0], oe};
      if (b0 + i < bq.size()) begin
        ao = {ao[62:0], bq[b0 + i] & oe};
        ae = {ae[62:0], oq[b0 + i]};
      end else begin
        ao = {ao[62:0], 1'b0};
        ae = {ae[62:0], 1'b0};
      end
    end
    chk({tag, "_mdio"}, ao, ee);
    chk({tag, "_oe"}, ae, eo);
  endtask

  task automatic run_cmd(input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] wdata, input logic [15:0] word,
                         input bit present, input logic [15:0] exp_rd, input string tag);
    int pre, t, r0;
    pre = sel ? PRE_B : PRE_A;
    phy_word = word; phy_present = present; phy_pre = pre;
    @(negedge clk);
    cmd_write = wr; cmd_phy_addr = phy; cmd_reg_addr = rg; cmd_wdata = wdata;
    cmd_valid = 1'b1;
    r0 = rsp_q.size();
    wait_accept(t);
    bq.delete(); oq.delete();
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk({tag, "_ready_busy"}, 64'({m_ready, m_busy}), 64'(2'b01));
    wait_rsp(r0 + 1);
    repeat (4) @(negedge clk);
    chk({tag, "_nrsp"}, 64'(rsp_q.size() - r0), 64'(1));
    chk({tag, "_nbits"}, 64'(bq.size()), 64'(pre + 32));
    check_frame(pre, wr, phy, rg, wdata, 0, tag);
    if (rsp_q.size() > r0) begin
      chk({tag, "_lat"}, 64'(rsp_q[r0]), 64'(t + 1 + (pre + 32) * 2 * D));
      chk({tag, "_rdata"}, 64'(rd_q[r0]), 64'(exp_rd));
    end
    if (!wr) last_rd[int'(sel)] = present ? word : 16'hFFFF;
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  phy, rg;
    logic [15:0] wdata, word;
    bit          present;
    logic [15:0] exp_rd;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int t1, t2, r0;
    bit wr, pr;
    logic [4:0] phy, rg;
    logic [15:0] wd, wo;

    tbl[0] = '{1'b1, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 5'h1F, 5'h02, 16'h0000, 16'hABCD, 1'b1, 16'hABCD};
    tbl[2] = '{1'b0, 5'h03, 5'h04, 16'h0000, 16'h0000, 1'b0, 16'hFFFF};
    tbl[3] = '{1'b1, 5'h03, 5'h04, 16'hBEEF, 16'h0000, 1'b0, 16'hFFFF};
    last_rd[0] = '0; last_rd[1] = '0;

    repeat (3) @(negedge clk);
    chk("reset_a", 64'({a_mdc, a_out, a_oe, a_ready, a_busy, a_rsp, a_rdata}), 64'({6'b010100, 16'h0000}));
    chk("reset_b", 64'({b_mdc, b_out, b_oe, b_ready, b_busy, b_rsp, b_rdata}), 64'({6'b010100, 16'h0000}));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_bus", 64'({a_mdc, a_oe, a_ready}), 64'(3'b001));

    for (int i = 0; i < 4; i++)
      run_cmd(tbl[i].wr, tbl[i].phy, tbl[i].rg, tbl[i].wdata, tbl[i].word,
              tbl[i].present, tbl[i].exp_rd, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      wr = 1'($urandom_range(0, 1)); pr = 1'($urandom_range(0, 1));
      phy = 5'($urandom); rg = 5'($urandom); wd = 16'($urandom); wo = 16'($urandom);
      run_cmd(wr, phy, rg, wd, wo, pr, wr ? last_rd[0] : (pr ? wo : 16'hFFFF),
              $sformatf("rand%0d", i));
    end

    // Back-to-back: valid held across two commands.
    phy_present = 1'b0; phy_pre = PRE_A;
    @(negedge clk);
    cmd_write = 1'b1; cmd_phy_addr = 5'h01; cmd_reg_addr = 5'h00; cmd_wdata = 16'h1140;
    cmd_valid = 1'b1;
    r0 = rsp_q.size();
    wait_accept(t1);
    bq.delete(); oq.delete();
    @(negedge clk);
    cmd_write = 1'b0; cmd_phy_addr = 5'h02; cmd_reg_addr = 5'h03;
    wait_accept(t2);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(r0 + 2);
    repeat (4) @(negedge clk);
    chk("b2b_nrsp", 64'(rsp_q.size() - r0), 64'(2));
    chk("b2b_nbits", 64'(bq.size()), 64'(128));
    check_frame(PRE_A, 1'b1, 5'h01, 5'h00, 16'h1140, 0, "b2b_f1");
    check_frame(PRE_A, 1'b0, 5'h02, 5'h03, 16'h0000, 64, "b2b_f2");
    if (rsp_q.size() >= r0 + 2) begin
      chk("b2b_lat1", 64'(rsp_q[r0]), 64'(t1 + 513));
      chk("b2b_accept2", 64'(t2), 64'(rsp_q[r0] + 2));
      chk("b2b_lat2", 64'(rsp_q[r0 + 1]), 64'(t2 + 513));
      chk("b2b_rd1", 64'(rd_q[r0]), 64'(last_rd[0]));
      chk("b2b_rd2", 64'(rd_q[r0 + 1]), 64'(16'hFFFF));
    end
    last_rd[0] = 16'hFFFF;
    chk("b2b_idle_ready", 64'(m_ready), 64'(1));

    // Reset in the middle of a read's DATA phase.
    phy_word = 16'h5A5A; phy_present = 1'b1; phy_pre = PRE_A;
    @(negedge clk);
    cmd_write = 1'b0; cmd_phy_addr = 5'h04; cmd_reg_addr = 5'h05; cmd_valid = 1'b1;
    r0 = rsp_q.size();
    wait_accept(t1);
    bq.delete(); oq.delete();
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < BUDGET && bq.size() < PRE_A + 20; i++) @(negedge clk);
    chk("rst_reached_data", 64'(bq.size() >= PRE_A + 20), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", 64'({m_mdc, m_oe, m_ready, m_rsp, m_rdata}), 64'({4'b0010, 16'h0000}));
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_rsp", 64'(rsp_q.size()), 64'(r0));
    last_rd[0] = '0; last_rd[1] = '0;
    run_cmd(1'b1, 5'h0A, 5'h1B, 16'hC3A5, 16'h0000, 1'b0, 16'h0000, "post_rst_wr");

    // Empty-preamble instance.
    sel = 1'b1;
    repeat (2) @(negedge clk);
    run_cmd(1'b1, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0, 16'h0000, "pre0_wr");
    run_cmd(1'b0, 5'h07, 5'h09, 16'h0000, 16'h1234, 1'b1, 16'h1234, "pre0_rd");
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mgmt_mdio_master.md
Name: mgmt_mdio_master

Overview:
- Clause-22 MDIO master for the management FPGA; fills the MDIO/reset/sensor TODO slot in the management top level.
- Directly downstream of the management controller: consumes single register-access commands (read/write, PHY addr, reg addr, data) over a valid/ready handshake.
- Serialises each command onto MDC/MDIO and returns one response per command.

Parameters:
- CLK_DIV, 50, clk cycles per MDC half-period (100 MHz / (2*50) = 1 MHz MDC); legal range 4..255.
- PREAMBLE_LEN, 32, number of preamble '1' bits per frame; legal range 0..32.

Ports:
- clk  in  1  system clock (100 MHz domain)
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_phy_addr  in  5  PHY address
- cmd_reg_addr  in  5  register address
- cmd_wdata  in  16  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse when the frame completes
- rsp_rdata  out  16  read data; valid from the rsp_valid pulse until the next read completes
- busy  out  1  frame in progress
- mdc  out  1  MDIO clock
- mdio_out  out  1  MDIO output data
- mdio_oe  out  1  MDIO output enable (tristate at top level)
- mdio_in  in  1  MDIO pad input (asynchronous)

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - mdc=0, mdio_out=1, mdio_oe=0.
  - cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=16'h0000.
  - State=IDLE, all counters 0.
- Reset mid-frame aborts immediately and drives the same values. No response is issued for the aborted command.
- Handshake:
  - A command is accepted on any clk edge with cmd_valid && cmd_ready. All command fields are latched on that edge.
  - cmd_ready = (state==IDLE); busy = !cmd_ready.
  - cmd_valid while busy is ignored. The producer must hold it.
- Frame format: PREAMBLE_LEN x '1', ST=01, OP (01 write / 10 read), PHYAD[4:0] MSB first, REGAD[4:0] MSB first, TA, DATA[15:0] MSB first.
  - TA on write: master drives '1','0'.
  - TA on read: mdio_oe=0 for both TA bits.
  - Total bits N = PREAMBLE_LEN + 32.
- Bit timing:
  - Each bit is a low phase of CLK_DIV clks (mdc=0) followed by a high phase of CLK_DIV clks (mdc=1).
  - mdio_out/mdio_oe update on the first clk of the low phase.
- Read sampling:
  - mdio_in passes through a 2-FF synchroniser.
  - Read data bits are sampled from the synchronised value on the last clk of each bit's high phase, shifted in MSB first.
- Read frames release the bus: mdio_oe=0 from the first TA bit through the last DATA bit.
- States:
  - IDLE -> PREAMBLE on accept. If PREAMBLE_LEN==0, go to HEADER instead.
  - PREAMBLE -> HEADER after PREAMBLE_LEN bits.
  - HEADER (14 bits: ST, OP, PHYAD, REGAD) -> TA after 14 bits.
  - TA -> DATA after 2 bits.
  - DATA -> DONE after 16 bits.
  - DONE -> IDLE after one cycle.
- DONE cycle:
  - rsp_valid=1, mdc=0, mdio_oe=0.
  - On a read, rsp_rdata is updated with the assembled word in the same cycle rsp_valid rises.
  - On a write, rsp_rdata is unchanged.
- Latency: accept at edge T; first bit's low phase begins at T+1; rsp_valid high at T+1+N*2*CLK_DIV. Default: 6401 clks.
- Back-to-back: cmd_ready returns the cycle after DONE. A new command accepted on that edge starts its first bit on the next clk. No extra idle MDC cycles.
- Absent PHY: the pull-up reads as all ones, so rsp_rdata=16'hFFFF. No error flag.
- Idle bus: mdc held at 0, mdio_oe=0.
- Counters:
  - Half-period counter: 8 bits, wraps at CLK_DIV-1.
  - Bit counter: 6 bits, reloaded per state.
  - No arithmetic overflow is possible within the legal parameter ranges.

Decomposition:
- Package mgmt_mdio_pkg:
  - State enum (IDLE, PREAMBLE, HEADER, TA, DATA, DONE).
  - Constants MDIO_ST=2'b01, MDIO_OP_WRITE=2'b01, MDIO_OP_READ=2'b10.
  - Field widths: PHYAD/REGAD=5, DATA=16.
- Sub-module mgmt_mdio_clkgen: half-period counter plus mdc. Outputs one-clk strobes bit_start (first low clk) and sample (last high clk); enable from the FSM.
- The FSM, shift registers and synchroniser stay in mgmt_mdio_master.

Test Plan:
- Write, CLK_DIV=4, phy=5'h01, reg=5'h00, wdata=16'h1140:
  - mdio_out sampled at each mdc rise = 32x'1', 01 01 00001 00000 10, then 0001000101000000.
  - mdio_oe=1 throughout; rsp_valid pulses once at accept+1+64*8 = accept+513.
- Read with a PHY model driving 16'hABCD, phy=5'h1F, reg=5'h02:
  - OP bits are 10; mdio_oe=0 from the first TA bit onward.
  - rsp_rdata=16'hABCD in the rsp_valid cycle.
- Read with no PHY (mdio_in tied 1): rsp_rdata=16'hFFFF.
- Read that follows it as a write: rsp_rdata stays 16'hFFFF.
- Back-to-back, cmd_valid held high for 2 commands:
  - The second is accepted the cycle after the first rsp_valid.
  - mdc shows no gap beyond one low DONE cycle.
  - cmd_ready=0 during frames; extra valid while busy is not consumed.
- rst_n asserted mid-DATA of a read:
  - Immediately mdc=0, mdio_oe=0, cmd_ready=1, rsp_valid never pulses.
  - After release, a fresh write completes correctly.
- PREAMBLE_LEN=0, CLK_DIV=4: frame is 32 bits; first driven bits are 0,1 (ST); rsp_valid at accept+257.
